// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync, clock filter, frame deserialiser,
// E0/F0 prefix folding and a small event FIFO with valid/ready pop.
module ps2_kbd_rx #(
  parameter int CLK_HZ         = 10_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FIFO_AW        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] last_byte,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            fclk_q, fclk_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic            fe;
  state_t          state_q, state_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            good, err;
  logic [7:0]      last_q;
  logic            ext_pend_q, brk_pend_q;
  logic            push_q, ferr_q;
  logic [9:0]      pdata_q;
  logic [9:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic            ovf_q, full, pop, wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fclk_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_i;
      dat_s2_q <= dat_s1_q;
      fclk_q   <= fclk_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Any sample matching the filtered level restarts the run count.
  always_comb begin
    fcnt_d = '0;
    fclk_d = fclk_q;
    if (clk_s2_q != fclk_q) begin
      if (fcnt_q == 4'(FILTER_LEN - 1)) fclk_d = clk_s2_q;
      else fcnt_d = fcnt_q + 4'd1;
    end
  end

  assign fe = fclk_q & ~fclk_d;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    err     = 1'b0;
    tcnt_d  = (fe || state_q == IDLE) ? '0 : tcnt_q + 1'b1;
    if (fe) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) good = 1'b1;
          else err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT_CYCLES)) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  // Prefix folding: E0/F0 only arm flags, any other byte becomes an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      push_q     <= 1'b0;
      pdata_q    <= '0;
      ferr_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= err;
      if (good) begin
        last_q <= shift_q;
        if (shift_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else begin
          push_q     <= 1'b1;
          pdata_q    <= {ext_pend_q, brk_pend_q, shift_q};
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
    end
  end

  assign full = (cnt_q == (FIFO_AW + 1)'(DEPTH));
  assign pop  = ev_valid & ev_ready;
  assign wr   = push_q & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= pdata_q;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (wr && !pop) cnt_q <= cnt_q + 1'b1;
      else if (!wr && pop) cnt_q <= cnt_q - 1'b1;
      if (push_q && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign ev_valid  = (cnt_q != '0);
  assign {ev_ext, ev_brk, ev_code} = mem_q[rptr_q];
  assign last_byte = last_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule
